us_rx_timestamp: RTL and testbench

US_RX_TIMESTAMP -- requirements
Module: us_rx_timestamp

---
 rtl/us_rx_timestamp_if.sv | 23 ++
 rtl/us_rx_timestamp.sv | 217 +++++++++++++++++++++
 tb/tb_us_rx_timestamp.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/us_rx_timestamp_if.sv
// Avalon-MM slave bus bundle for us_rx_timestamp (register access path).
`timescale 1ns/1ps
interface us_rx_timestamp_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] avalon_slave_address;
  logic              avalon_slave_read;
  logic              avalon_slave_write;
  logic [DATA_W-1:0] avalon_slave_writedata;
  logic [DATA_W-1:0] avalon_slave_readdata;
  logic              avalon_slave_waitrequest;

  modport master (
    output avalon_slave_address, avalon_slave_read, avalon_slave_write, avalon_slave_writedata,
    input  avalon_slave_readdata, avalon_slave_waitrequest
  );

  modport slave (
    input  avalon_slave_address, avalon_slave_read, avalon_slave_write, avalon_slave_writedata,
    output avalon_slave_readdata, avalon_slave_waitrequest
  );
endinterface

// File: rtl/us_rx_timestamp.sv
// Piezo RX burst detector: timestamps the first edge of each qualifying burst into a 4-deep FIFO.
// Define US_RX_IRQ_EN to enable the irq output and the irq_en control bit.
`timescale 1ns/1ps
module us_rx_timestamp (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_in,
  input  logic [31:0]             time_cnt,
  us_rx_timestamp_if.slave        avalon_slave,
  output logic                    irq
);

  localparam int unsigned TS_W   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PCNT_W = 8;
  localparam int unsigned GAP_W  = 16;

  localparam logic [15:0] ADDR_FIFO   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0001;
  localparam logic [15:0] ADDR_MIN    = 16'h0002;
  localparam logic [15:0] ADDR_GAP    = 16'h0003;
  localparam logic [15:0] ADDR_CTRL   = 16'h0004;

`ifdef US_RX_IRQ_EN
  localparam bit IRQ_SUPPORT = 1'b1;
`else
  localparam bit IRQ_SUPPORT = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, IN_BURST = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                rx_meta, rx_sync, rx_prev;
  logic                rx_rise;
  logic [TS_W-1:0]     ts_first;
  logic [PCNT_W-1:0]   pulse_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [PCNT_W-1:0]   min_pulses;
  logic [GAP_W-1:0]    gap_limit;
  logic                armed;
  logic                irq_en;
  logic                overflow;
  logic [PCNT_W-1:0]   min_eff;
  logic [GAP_W-1:0]    gap_eff;
  logic                start_c, count_c, burst_end_c, push_c;
  logic [TS_W-1:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                empty_c, full_c, pop_c, push_ok_c;
  logic                rd_c, wr_c;
  logic [15:0]         addr;
  logic [31:0]         wdata;
  logic [31:0]         rdata_c;

  assign addr  = avalon_slave.avalon_slave_address;
  assign wdata = avalon_slave.avalon_slave_writedata;
  assign rd_c  = avalon_slave.avalon_slave_read;
  assign wr_c  = avalon_slave.avalon_slave_write;
  assign avalon_slave.avalon_slave_waitrequest = 1'b0;

  // Two-flop synchronizer plus one history flop for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_rise = rx_sync & ~rx_prev;
  assign min_eff = (min_pulses == '0) ? PCNT_W'(1) : min_pulses;
  assign gap_eff = (gap_limit == '0) ? GAP_W'(1) : gap_limit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_c) state_d = IN_BURST;
      IN_BURST: if (!armed || burst_end_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // An edge landing in the burst-end cycle is dropped: count_c is low then
  always_comb begin
    start_c     = 1'b0;
    count_c     = 1'b0;
    burst_end_c = 1'b0;
    push_c      = 1'b0;
    case (state_q)
      IDLE: start_c = armed & rx_rise;
      IN_BURST: begin
        if (armed) begin
          if (gap_cnt == gap_eff) begin
            burst_end_c = 1'b1;
            push_c      = (pulse_cnt >= min_eff);
          end else begin
            count_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_first  <= '0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
    end else if (start_c) begin
      ts_first  <= time_cnt;
      pulse_cnt <= PCNT_W'(1);
      gap_cnt   <= '0;
    end else if (count_c) begin
      if (rx_rise) begin
        if (pulse_cnt != {PCNT_W{1'b1}}) pulse_cnt <= pulse_cnt + PCNT_W'(1);
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // A push into a full FIFO still lands when a pop frees the head in the same cycle
  assign empty_c   = (fifo_cnt == '0);
  assign full_c    = (fifo_cnt == CNT_W'(DEPTH));
  assign pop_c     = rd_c && (addr == ADDR_FIFO) && !empty_c;
  assign push_ok_c = push_c && (!full_c || pop_c);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok_c) fifo_mem[wr_ptr] <= ts_first;
  end

  // A new overflow event wins over a same-cycle clear so it is never lost
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_c && full_c && !pop_c) begin
      overflow <= 1'b1;
    end else if (wr_c && (addr == ADDR_STATUS) && wdata[0]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_pulses <= PCNT_W'(3);
      gap_limit  <= GAP_W'(100);
      armed      <= 1'b0;
      irq_en     <= 1'b0;
    end else if (wr_c) begin
      case (addr)
        ADDR_MIN: min_pulses <= wdata[PCNT_W-1:0];
        ADDR_GAP: gap_limit  <= wdata[GAP_W-1:0];
        ADDR_CTRL: begin
          armed  <= wdata[0];
          irq_en <= IRQ_SUPPORT & wdata[1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    case (addr)
      ADDR_FIFO:   rdata_c = empty_c ? 32'hFFFF_FFFF : fifo_mem[rd_ptr];
      ADDR_STATUS: rdata_c = {27'b0, overflow, fifo_cnt, empty_c};
      ADDR_MIN:    rdata_c = {24'b0, min_pulses};
      ADDR_GAP:    rdata_c = {16'b0, gap_limit};
      ADDR_CTRL:   rdata_c = {30'b0, irq_en, armed};
      default:     rdata_c = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     avalon_slave.avalon_slave_readdata <= '0;
    else if (rd_c) avalon_slave.avalon_slave_readdata <= rdata_c;
  end

`ifdef US_RX_IRQ_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_en & (~empty_c | overflow);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_us_rx_timestamp.sv
// Bench for us_rx_timestamp: directed scenarios plus random pulse trains checked against a burst-level model.
`timescale 1ns/1ps
module tb_us_rx_timestamp;

  logic        clock;
  logic        reset;
  logic        rx_in;
  logic        irq;
  logic [31:0] time_cnt;
  logic        tc_load;
  logic [31:0] tc_load_val;

  int checks = 0;
  int errors = 0;
  int irq_hits = 0;

  // Behavioural model state: effective config, open burst, expected FIFO contents
  int unsigned m_gap;
  int unsigned m_min;
  bit          m_armed;
  bit          m_in;
  bit          m_ovf;
  int unsigned m_cnt;
  logic [31:0] m_first;
  logic [31:0] m_last;
  logic [31:0] exp_q[$];

  us_rx_timestamp_if bus();

  us_rx_timestamp dut (
    .clock        (clock),
    .reset        (reset),
    .rx_in        (rx_in),
    .time_cnt     (time_cnt),
    .avalon_slave (bus),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(posedge clock) time_cnt <= tc_load ? tc_load_val : time_cnt + 32'd1;

  always @(negedge clock) if (irq === 1'b1) irq_hits++;

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.avalon_slave_address   = a;
    bus.avalon_slave_writedata = d;
    bus.avalon_slave_write     = 1'b1;
    @(negedge clock);
    bus.avalon_slave_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clock);
    bus.avalon_slave_address = a;
    bus.avalon_slave_read    = 1'b1;
    @(negedge clock);
    bus.avalon_slave_read    = 1'b0;
    d = bus.avalon_slave_readdata;
  endtask

  // Model: a burst closes when the quiet time after its last counted edge exceeds the gap;
  // an edge exactly one cycle past the gap coincides with the close and is lost.
  task automatic model_close();
    if (m_in) begin
      if (m_cnt >= m_min) begin
        if (exp_q.size() < 4) exp_q.push_back(m_first);
        else m_ovf = 1'b1;
      end
      m_in = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [31:0] t);
    logic [31:0] d;
    if (!m_armed) return;
    if (m_in) begin
      d = t - m_last;
      if (d <= m_gap) begin
        if (m_cnt < 255) m_cnt++;
        m_last = t;
        return;
      end
      model_close();
      if (d == m_gap + 1) return;
    end
    m_in    = 1'b1;
    m_first = t;
    m_last  = t;
    m_cnt   = 1;
  endtask

  function automatic logic [31:0] exp_status();
    return {27'b0, m_ovf, 3'(exp_q.size()), exp_q.size() == 0};
  endfunction

  // Synchronized edge shows up two cycles after the rise, tagged with that cycle's time_cnt
  task automatic send_pulse();
    logic [31:0] ts;
    ts    = time_cnt + 32'd2;
    rx_in = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rx_in = 1'b0;
    model_edge(ts);
  endtask

  task automatic pulse_after(input int sp);
    repeat (sp - 2) @(negedge clock);
    send_pulse();
  endtask

  task automatic send_burst(input int n, input int sp);
    send_pulse();
    for (int i = 1; i < n; i++) pulse_after(sp);
  endtask

  task automatic settle();
    repeat (m_gap + 20) @(negedge clock);
    model_close();
  endtask

  task automatic set_cfg(input int unsigned min_raw, input int unsigned gap_raw);
    bus_write(16'h0002, 32'(min_raw));
    bus_write(16'h0003, 32'(gap_raw));
    m_min = (min_raw == 0) ? 1 : min_raw;
    m_gap = (gap_raw == 0) ? 1 : gap_raw;
  endtask

  task automatic set_ctrl(input bit arm, input bit ien);
    bus_write(16'h0004, {30'b0, ien, arm});
    if (!arm) m_in = 1'b0;
    m_armed = arm;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(16'h0001, d);
    check(tag, d, exp_status());
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      bus_read(16'h0000, d);
      check(tag, d, exp_q.pop_front());
    end
    bus_read(16'h0000, d);
    check({tag, "_empty"}, d, 32'hFFFF_FFFF);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_in    = 1'b0;
    m_armed = 1'b0;
    m_min   = 3;
    m_gap   = 100;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] last_e;
    int guard;
    int sp;
    int npulse;

    reset = 1'b1;
    rx_in = 1'b0;
    tc_load = 1'b1;
    tc_load_val = 32'd0;
    bus.avalon_slave_address   = '0;
    bus.avalon_slave_read      = 1'b0;
    bus.avalon_slave_write     = 1'b0;
    bus.avalon_slave_writedata = '0;
    model_reset();
    m_cnt = 0;
    m_first = '0;
    m_last = '0;

    repeat (3) @(negedge clock);
    check("rst_readdata", bus.avalon_slave_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tc_load = 1'b0;
    reset = 1'b0;

    bus_read(16'h0002, d); check("rst_min", d, 32'd3);
    bus_read(16'h0003, d); check("rst_gap", d, 32'd100);
    bus_read(16'h0004, d); check("rst_ctrl", d, 32'd0);
    check_status("rst_status");
    bus_read(16'h0007, d); check("unmapped_rd", d, 32'h0);

    // Scenario 1: five pulses, first edge stamped 0x1000
    set_ctrl(1'b1, 1'b0);
    @(negedge clock);
    tc_load = 1'b1; tc_load_val = 32'h0000_0FFE;
    @(negedge clock);
    tc_load = 1'b0;
    send_pulse();
    for (int i = 1; i < 5; i++) pulse_after(20);
    settle();
    bus_read(16'h0001, d); check("sc1_status", d, 32'h0000_0002);
    bus_read(16'h0000, d); check("sc1_ts", d, 32'h0000_1000);
    void'(exp_q.pop_front());
    check_status("sc1_empty");

    // Scenario 2: burst below min_pulses is dropped
    send_burst(2, 20);
    settle();
    bus_read(16'h0001, d); check("sc2_status", d, 32'h0000_0001);

    // Scenario 3: six valid bursts overflow a 4-deep FIFO
    for (int b = 0; b < 6; b++) begin
      send_burst(3, 10);
      settle();
    end
    bus_read(16'h0001, d); check("sc3_status", d, 32'h0000_0018);
    check_status("sc3_model_status");
    drain("sc3_pop");
    bus_write(16'h0001, 32'h1);
    m_ovf = 1'b0;
    check_status("sc3_ovf_clr");

    // Scenario 4: pop in the exact cycle a push hits a full FIFO
    set_cfg(3, 20);
    for (int b = 0; b < 4; b++) begin
      send_burst(3, 10);
      settle();
    end
    check_status("sc4_full");
    send_burst(3, 10);
    last_e = m_last;
    guard = 0;
    while (time_cnt != last_e + 32'(m_gap) + 32'd1 && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check("sc4_wait", 32'(guard >= 1000), 32'h0);
    bus.avalon_slave_address = 16'h0000;
    bus.avalon_slave_read    = 1'b1;
    @(negedge clock);
    bus.avalon_slave_read    = 1'b0;
    check("sc4_head", bus.avalon_slave_readdata, exp_q.pop_front());
    settle();
    check_status("sc4_status");
    drain("sc4_pop");

    // Scenario 6: interrupt behaviour
    set_cfg(3, 100);
    set_ctrl(1'b1, 1'b1);
`ifdef US_RX_IRQ_EN
    bus_read(16'h0004, d); check("sc6_ctrl", d, 32'h3);
`else
    bus_read(16'h0004, d); check("sc6_ctrl", d, 32'h1);
`endif
    check("sc6_irq_idle", {31'b0, irq}, 32'h0);
    send_burst(3, 10);
    settle();
`ifdef US_RX_IRQ_EN
    check("sc6_irq_set", {31'b0, irq}, 32'h1);
`else
    check("sc6_irq_set", {31'b0, irq}, 32'h0);
`endif
    drain("sc6_pop");
    repeat (3) @(negedge clock);
    check("sc6_irq_clr", {31'b0, irq}, 32'h0);
    set_ctrl(1'b1, 1'b0);

    // Scenario 5a: disarm mid-burst aborts without a push
    set_cfg(1, 20);
    send_pulse();
    pulse_after(10);
    set_ctrl(1'b0, 1'b0);
    pulse_after(10);
    pulse_after(10);
    settle();
    check_status("sc5_disarm");
    set_ctrl(1'b1, 1'b0);
    send_burst(1, 10);
    settle();
    check_status("sc5_rearm");
    drain("sc5_pop");

    // Scenario 5b: reset with data queued and a burst open
    send_burst(2, 10);
    settle();
    send_pulse();
    pulse_after(10);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("sc5_rst_readdata", bus.avalon_slave_readdata, 32'h0);
    check("sc5_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    bus_read(16'h0002, d); check("sc5_rst_min", d, 32'd3);
    bus_read(16'h0003, d); check("sc5_rst_gap", d, 32'd100);
    bus_read(16'h0004, d); check("sc5_rst_ctrl", d, 32'd0);
    settle();
    bus_read(16'h0001, d); check("sc5_rst_status", d, 32'h1);

    // Random pulse trains against the model
    set_ctrl(1'b1, 1'b0);
    for (int t = 0; t < 25; t++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 30));
      npulse = $urandom_range(1, 12);
      send_pulse();
      for (int j = 1; j < npulse; j++) begin
        case ($urandom_range(0, 3))
          0, 1:    sp = (m_gap >= 4) ? int'($urandom_range(4, m_gap)) : int'(m_gap) + 4;
          2:       sp = (m_gap + 1 >= 4) ? int'(m_gap) + 1 : int'(m_gap) + 4;
          default: sp = int'(m_gap) + 2 + int'($urandom_range(2, 20));
        endcase
        pulse_after(sp);
      end
      settle();
      check_status("rnd_status");
      drain("rnd_pop");
      bus_write(16'h0001, 32'h1);
      m_ovf = 1'b0;
      check_status("rnd_ovf_clr");
    end

`ifndef US_RX_IRQ_EN
    check("irq_never_high", 32'(irq_hits), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
